// File: rtl/frontend_stream_merge.sv
// frontend_stream_merge: merges time-tag words and multi-word event packets into one
// 128-bit stream; time tags only win at packet boundaries, output buffered by a small FIFO.
module frontend_stream_merge #(
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_PKT_WORDS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tt_valid,
    output logic         tt_ready,
    input  logic [127:0] tt_data,
    output logic         stall,
    input  logic         ev_valid,
    output logic         ev_ready,
    input  logic [127:0] ev_data,
    input  logic         ev_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [15:0]  tt_count,
    output logic [31:0]  pkt_count,
    output logic         pkt_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(MAX_PKT_WORDS);

    typedef enum logic {IDLE, PACKET} state_t;

    state_t         state_q, state_d;
    logic [WW-1:0]  word_cnt_q, word_cnt_d;
    logic [AW:0]    count_q, count_d;
    logic [AW-1:0]  wr_q, rd_q;
    logic [127:0]   mem_q [FIFO_DEPTH];
    logic           armed_q, stall_q, pkt_err_q;
    logic [15:0]    tt_count_q;
    logic [31:0]    pkt_count_q;
    logic           space, tt_acc, ev_acc, push, pop, forced, close_pkt;

    // armed_q holds the ready signals low until the first cycle after reset release
    assign space     = armed_q && (count_q < (AW+1)'(FIFO_DEPTH));
    assign tt_ready  = (state_q == IDLE) && space;
    assign ev_ready  = space && ((state_q == PACKET) || !tt_valid);
    assign tt_acc    = tt_valid && tt_ready;
    assign ev_acc    = ev_valid && ev_ready;
    assign push      = tt_acc || ev_acc;
    assign forced    = ev_acc && (state_q == PACKET) && !ev_last && (word_cnt_q == WW'(MAX_PKT_WORDS - 1));
    assign close_pkt = ev_acc && (ev_last || forced);
    assign out_valid = count_q != '0;
    assign out_data  = mem_q[rd_q];
    assign pop       = out_valid && out_ready;
    assign stall     = stall_q;
    assign tt_count  = tt_count_q;
    assign pkt_count = pkt_count_q;
    assign pkt_err   = pkt_err_q;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        if (ev_acc) begin
            state_d    = close_pkt ? IDLE : PACKET;
            word_cnt_d = (state_q == IDLE) ? WW'(1) : word_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            count_q     <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            armed_q     <= 1'b0;
            stall_q     <= 1'b0;
            pkt_err_q   <= 1'b0;
            tt_count_q  <= '0;
            pkt_count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            count_q     <= count_d;
            armed_q     <= 1'b1;
            stall_q     <= state_d == PACKET;
            pkt_err_q   <= pkt_err_q || forced;
            tt_count_q  <= tt_count_q + 16'(tt_acc);
            pkt_count_q <= pkt_count_q + 32'(close_pkt);
            if (push) begin
                mem_q[wr_q] <= tt_acc ? tt_data : ev_data;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_frontend_stream_merge.sv
// tb_frontend_stream_merge: randomized scoreboard bench with a packet-level reference model.
module tb_frontend_stream_merge;
    localparam int DEPTH = 4;
    localparam int MAXW  = 16;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         tt_valid = 1'b0, tt_ready, stall;
    logic         ev_valid = 1'b0, ev_ready, ev_last = 1'b0;
    logic         out_valid, out_ready = 1'b0, pkt_err;
    logic [127:0] tt_data = '0, ev_data = '0, out_data;
    logic [15:0]  tt_count;
    logic [31:0]  pkt_count;

    frontend_stream_merge #(.FIFO_DEPTH(DEPTH), .MAX_PKT_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .tt_valid(tt_valid), .tt_ready(tt_ready), .tt_data(tt_data), .stall(stall),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .ev_last(ev_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .tt_count(tt_count), .pkt_count(pkt_count), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [127:0] d; logic l;} ev_t;

    logic [127:0] tt_pend[$];
    ev_t          ev_pend[$];
    logic [127:0] exp_q[$];
    int checks = 0, errors = 0;
    int p_rdy = 100, p_tt = 100, p_ev = 100;

    // reference model: FIFO occupancy, words in the open packet, counters
    int occ = 0, plen = 0, m_tt = 0, m_pkt = 0;
    bit m_err = 0, armed = 0;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(negedge clk) begin
        bit sp, etr, eer, tta, eva, pop;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_stall", stall, 0);
            chk("rst_tt_count", tt_count, 0);
            chk("rst_pkt_count", pkt_count, 0);
            chk("rst_pkt_err", pkt_err, 0);
            chk("rst_tt_ready", tt_ready, 0);
            chk("rst_ev_ready", ev_ready, 0);
            occ = 0; plen = 0; m_tt = 0; m_pkt = 0; m_err = 0; armed = 0;
        end else begin
            sp  = armed && occ < DEPTH;
            etr = plen == 0 && sp;
            eer = sp && (plen != 0 || !tt_valid);
            chk("tt_ready", tt_ready, etr);
            chk("ev_ready", ev_ready, eer);
            chk("stall", stall, plen != 0);
            chk("out_valid", out_valid, occ != 0);
            chk("tt_count", tt_count, 16'(m_tt));
            chk("pkt_count", pkt_count, 32'(m_pkt));
            chk("pkt_err", pkt_err, m_err);
            pop = occ != 0 && out_ready;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_unexpected got %h want none", out_data);
                end else chk("out_data", out_data, exp_q.pop_front());
            end
            tta = tt_valid && etr;
            eva = ev_valid && eer;
            occ = occ + int'(tta || eva) - int'(pop);
            if (tta) m_tt++;
            if (eva) begin
                plen++;
                if (ev_last || plen == MAXW) begin
                    m_pkt++;
                    if (!ev_last) m_err = 1;
                    plen = 0;
                end
            end
            armed = 1;
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            tt_valid  = tt_pend.size() > 0 && !stall && $urandom_range(99) < p_tt;
            tt_data   = tt_pend.size() > 0 ? tt_pend[0] : '0;
            ev_valid  = ev_pend.size() > 0 && $urandom_range(99) < p_ev;
            ev_data   = ev_pend.size() > 0 ? ev_pend[0].d : '0;
            ev_last   = ev_pend.size() > 0 ? ev_pend[0].l : 1'b0;
            out_ready = $urandom_range(99) < p_rdy;
            @(negedge clk);
            if (tt_valid && tt_ready) exp_q.push_back(tt_pend.pop_front());
            if (ev_valid && ev_ready) begin
                exp_q.push_back(ev_pend[0].d);
                void'(ev_pend.pop_front());
            end
        end
    endtask

    task automatic add_pkt(input int n, input bit last);
        for (int i = 0; i < n; i++) ev_pend.push_back('{rnd128(), last && i == n - 1});
    endtask

    task automatic drain();
        p_rdy = 100; p_tt = 100; p_ev = 100;
        for (int i = 0; i < 300 && (exp_q.size() + tt_pend.size() + ev_pend.size()) > 0; i++) run(1);
        run(3);
        chk("drain_left", exp_q.size() + tt_pend.size() + ev_pend.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; tt_valid = 1'b0; ev_valid = 1'b0;
        exp_q.delete(); tt_pend.delete(); ev_pend.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] first_tt;
        first_tt = {8'hF8, 116'h0, 4'h1};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tt_pend.push_back(first_tt);
        run(4);
        add_pkt(3, 1);
        run(1);
        tt_pend.push_back(rnd128());
        run(8);
        add_pkt(1, 1);
        tt_pend.push_back(rnd128());
        run(6);
        p_rdy = 0;
        repeat (3) tt_pend.push_back(rnd128());
        add_pkt(3, 1);
        run(10);
        drain();
        add_pkt(20, 1);
        run(1);
        tt_pend.push_back(rnd128());
        drain();
        p_rdy = 0;
        add_pkt(5, 1);
        run(4);
        do_reset();
        tt_pend.push_back(rnd128());
        add_pkt(2, 1);
        drain();
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(1)) tt_pend.push_back(rnd128());
            if ($urandom_range(1)) add_pkt($urandom_range(1, 20), $urandom_range(9) != 0);
            p_rdy = $urandom_range(20, 100);
            p_tt  = $urandom_range(30, 100);
            p_ev  = $urandom_range(30, 100);
            run($urandom_range(5, 40));
        end
        add_pkt(1, 1);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
